vga_readback_dma: RTL and testbench

// - CPU-programmed rectangle copy in the reverse direction of the blitter: reads a

---
 rtl/vga_readback_dma.sv | 162 ++++++++++++++++
 tb/tb_vga_readback_dma.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_readback_dma.sv
// rtl/vga_readback_dma.sv - VRAM-to-RAM rectangle readback engine (optional VGA_READBACK_SKIP_ZERO_EN)
module vga_readback_dma #(
    parameter int RAM_ROW_W  = 5,
    parameter int RAM_PAGE_W = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_b,
    input  logic                    i_cpu_ce_b,
    input  logic                    i_cpu_we_b,
    input  logic [2:0]              i_cpu_addr,
    input  logic [7:0]              i_cpu_data,
    output logic [7:0]              o_cpu_rdata,
    input  logic                    i_free_vbus_b,
    output logic                    o_vram_re_b,
    output logic [15:0]             o_vram_addr,
    input  logic [7:0]              i_vram_data,
    output logic                    o_ram_we_b,
    output logic [RAM_ROW_W+7:0]    o_ram_addr,
    output logic [RAM_PAGE_W-1:0]   o_ram_page,
    output logic [7:0]              o_ram_data,
    output logic                    o_active
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_READ, S_WRITE} state_t;

    state_t state, state_nxt;

    logic [7:0] vx, vy, rx, r3, width, height;
    logic [7:0] xo, yo, pixel;
    logic       cpu_wr, busy, start, abort, last_px, skip_hit;
    logic [RAM_ROW_W-1:0] ry, ram_row;
    logic [7:0] ram_col, vram_x, vram_y;

    assign cpu_wr  = !i_cpu_ce_b && !i_cpu_we_b;
    assign busy    = (state != S_IDLE);
    assign start   = cpu_wr && (i_cpu_addr == 3'd7) && !i_cpu_data[7] && !busy;
    assign abort   = cpu_wr && (i_cpu_addr == 3'd7) &&  i_cpu_data[7] &&  busy;
    assign last_px = (xo == width) && (yo == height);

    // Register 3 packs the RAM row base below the page select.
    assign ry         = r3[RAM_ROW_W-1:0];
    assign o_ram_page = r3[RAM_ROW_W +: RAM_PAGE_W];

    assign vram_x      = vx + xo;
    assign vram_y      = vy + yo;
    assign ram_row     = ry + yo[RAM_ROW_W-1:0];
    assign ram_col     = rx + xo;
    assign o_vram_addr = {vram_y, vram_x};
    assign o_ram_addr  = {ram_row, ram_col};
    assign o_ram_data  = pixel;

`ifdef VGA_READBACK_SKIP_ZERO_EN
    logic skip_zero;

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b)
            skip_zero <= 1'b0;
        else if (start)
            skip_zero <= i_cpu_data[0];
    end

    assign skip_hit = skip_zero && (pixel == 8'h00);
`else
    assign skip_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_READ;
            S_READ:  if (!i_free_vbus_b) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_px ? S_IDLE : S_READ;
            default: state_nxt = S_IDLE;
        endcase
        if (abort)
            state_nxt = S_IDLE;
    end

    always_comb begin
        o_active    = 1'b0;
        o_vram_re_b = 1'b1;
        o_ram_we_b  = 1'b1;
        case (state)
            S_ARM:   o_active = 1'b1;
            S_READ: begin
                o_active    = 1'b1;
                o_vram_re_b = i_free_vbus_b;
            end
            S_WRITE: begin
                o_active   = 1'b1;
                o_ram_we_b = skip_hit;
            end
            default: o_active = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            vx     <= 8'h00;
            vy     <= 8'h00;
            rx     <= 8'h00;
            r3     <= 8'h00;
            width  <= 8'h00;
            height <= 8'h00;
            xo     <= 8'h00;
            yo     <= 8'h00;
            pixel  <= 8'h00;
        end else begin
            if (cpu_wr && !busy) begin
                case (i_cpu_addr)
                    3'd0:    vx     <= i_cpu_data;
                    3'd1:    vy     <= i_cpu_data;
                    3'd2:    rx     <= i_cpu_data;
                    3'd3:    r3     <= i_cpu_data;
                    3'd4:    width  <= i_cpu_data;
                    3'd5:    height <= i_cpu_data;
                    default: ;
                endcase
            end
            if (start) begin
                xo <= 8'h00;
                yo <= 8'h00;
            end
            if (state == S_READ && !i_free_vbus_b)
                pixel <= i_vram_data;
            // Column-major walk: finish a column before moving right.
            if (state == S_WRITE && !abort && !last_px) begin
                if (yo != height) begin
                    yo <= yo + 8'd1;
                end else begin
                    yo <= 8'h00;
                    xo <= xo + 8'd1;
                end
            end
        end
    end

    always_comb begin
        o_cpu_rdata = 8'h00;
        if (!i_cpu_ce_b) begin
            case (i_cpu_addr)
                3'd0:    o_cpu_rdata = vx;
                3'd1:    o_cpu_rdata = vy;
                3'd2:    o_cpu_rdata = rx;
                3'd3:    o_cpu_rdata = r3;
                3'd4:    o_cpu_rdata = width;
                3'd5:    o_cpu_rdata = height;
                3'd7:    o_cpu_rdata = {busy, 7'h00};
                default: o_cpu_rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_readback_dma.sv
// tb/tb_vga_readback_dma.sv - directed bench for vga_readback_dma
module tb_vga_readback_dma;

    logic        i_clk = 1'b0;
    logic        i_rst_b = 1'b0;
    logic        i_cpu_ce_b = 1'b1;
    logic        i_cpu_we_b = 1'b1;
    logic [2:0]  i_cpu_addr = 3'd0;
    logic [7:0]  i_cpu_data = 8'h00;
    logic [7:0]  o_cpu_rdata;
    logic        i_free_vbus_b = 1'b0;
    logic        o_vram_re_b;
    logic [15:0] o_vram_addr;
    logic [7:0]  i_vram_data;
    logic        o_ram_we_b;
    logic [12:0] o_ram_addr;
    logic [1:0]  o_ram_page;
    logic [7:0]  o_ram_data;
    logic        o_active;

    logic [7:0] vram [0:65535];

    int tests = 0;
    int failed = 0;
    int act_cycles = 0;
    int stall_strobes = 0;
    logic in_stall = 1'b0;
    int wa_q[$];
    int wd_q[$];
    int wp_q[$];
    int ra_q[$];

    vga_readback_dma dut (
        .i_clk         (i_clk),
        .i_rst_b       (i_rst_b),
        .i_cpu_ce_b    (i_cpu_ce_b),
        .i_cpu_we_b    (i_cpu_we_b),
        .i_cpu_addr    (i_cpu_addr),
        .i_cpu_data    (i_cpu_data),
        .o_cpu_rdata   (o_cpu_rdata),
        .i_free_vbus_b (i_free_vbus_b),
        .o_vram_re_b   (o_vram_re_b),
        .o_vram_addr   (o_vram_addr),
        .i_vram_data   (i_vram_data),
        .o_ram_we_b    (o_ram_we_b),
        .o_ram_addr    (o_ram_addr),
        .o_ram_page    (o_ram_page),
        .o_ram_data    (o_ram_data),
        .o_active      (o_active)
    );

    always #5 i_clk = ~i_clk;

    assign i_vram_data = vram[o_vram_addr];

    always @(negedge i_clk) begin
        if (!o_ram_we_b) begin
            wa_q.push_back(int'(o_ram_addr));
            wd_q.push_back(int'(o_ram_data));
            wp_q.push_back(int'(o_ram_page));
        end
        if (!o_vram_re_b)
            ra_q.push_back(int'(o_vram_addr));
        if (o_active)
            act_cycles++;
        if (in_stall && (!o_vram_re_b || !o_ram_we_b))
            stall_strobes++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        i_cpu_ce_b = 1'b0;
        i_cpu_we_b = 1'b0;
        i_cpu_addr = a;
        i_cpu_data = d;
        @(posedge i_clk); #1;
        i_cpu_ce_b = 1'b1;
        i_cpu_we_b = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        i_cpu_ce_b = 1'b0;
        i_cpu_we_b = 1'b1;
        i_cpu_addr = a;
        #1;
        d = o_cpu_rdata;
        i_cpu_ce_b = 1'b1;
    endtask

    task automatic setup(input logic [7:0] vx, input logic [7:0] vy, input logic [7:0] rx,
                         input logic [7:0] r3, input logic [7:0] w, input logic [7:0] h);
        cpu_write(3'd0, vx);
        cpu_write(3'd1, vy);
        cpu_write(3'd2, rx);
        cpu_write(3'd3, r3);
        cpu_write(3'd4, w);
        cpu_write(3'd5, h);
        wa_q.delete();
        wd_q.delete();
        wp_q.delete();
        ra_q.delete();
        act_cycles = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_active && n < 2000) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (o_active) begin
            failed++;
            $display("FAIL %s: copy did not finish within 2000 cycles", tag);
        end
    endtask

    task automatic wait_writes(input int cnt, input string tag);
        int n;
        n = 0;
        while (wd_q.size() < cnt && n < 500) begin
            @(posedge i_clk); #1;
            n++;
        end
        check(tag, wd_q.size(), cnt);
    endtask

    task automatic check_2x3(input string tag);
        int k;
        check({tag, "_count"}, wd_q.size(), 6);
        k = 0;
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 3; y++) begin
                if (k < wd_q.size()) begin
                    check({tag, "_addr"}, wa_q[k], ((2 + y) << 8) | (8'h10 + x));
                    check({tag, "_data"}, wd_q[k], int'(vram[16'(((8'h50 + y) << 8) | (8'h40 + x))]));
                    check({tag, "_page"}, wp_q[k], 2);
                end
                k++;
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        for (int i = 0; i < 65536; i++)
            vram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_active", o_active, 1'b0);
        check("rst_re_b", o_vram_re_b, 1'b1);
        check("rst_we_b", o_ram_we_b, 1'b1);
        check("rst_vram_addr", o_vram_addr, 16'h0000);
        check("rst_ram_addr", o_ram_addr, 13'h0000);
        check("rst_ram_data", o_ram_data, 8'h00);
        i_rst_b = 1'b1;
        @(posedge i_clk); #1;
        cpu_read(3'd7, rd);
        check("rst_state", rd, 8'h00);

        // Register readback and abort while idle
        cpu_write(3'd3, 8'h63);
        cpu_read(3'd3, rd);
        check("reg3_rb", rd, 8'h63);
        cpu_write(3'd7, 8'h80);
        #1;
        check("idle_abort_active", o_active, 1'b0);

        // 1x1 copy
        vram[16'h2010] = 8'hA5;
        setup(8'h10, 8'h20, 8'h05, 8'h03, 8'h00, 8'h00);
        cpu_write(3'd7, 8'h00);
        wait_idle("1x1");
        check("1x1_count", wd_q.size(), 1);
        check("1x1_addr", wa_q.size() > 0 ? wa_q[0] : -1, 13'h0305);
        check("1x1_data", wd_q.size() > 0 ? wd_q[0] : -1, 8'hA5);
        check("1x1_active", act_cycles, 3);

        // 2x3 copy, page 2; busy readback and register write ignored while busy
        setup(8'h40, 8'h50, 8'h10, 8'h42, 8'h01, 8'h02);
        cpu_write(3'd7, 8'h00);
        cpu_read(3'd7, rd);
        check("busy_rb", rd, 8'h80);
        cpu_write(3'd0, 8'h99);
        wait_idle("2x3");
        check_2x3("2x3");
        check("2x3_active", act_cycles, 13);
        cpu_read(3'd0, rd);
        check("busy_write_ignored", rd, 8'h40);

        // Same copy with a 5-cycle stall starting on the second read
        setup(8'h40, 8'h50, 8'h10, 8'h42, 8'h01, 8'h02);
        cpu_write(3'd7, 8'h00);
        repeat (3) begin @(posedge i_clk); #1; end
        i_free_vbus_b = 1'b1;
        in_stall = 1'b1;
        repeat (5) begin @(posedge i_clk); #1; end
        i_free_vbus_b = 1'b0;
        in_stall = 1'b0;
        wait_idle("stall");
        check("stall_strobes", stall_strobes, 0);
        check_2x3("stall");
        check("stall_active", act_cycles, 18);

        // Address wrap on VRAM x and RAM row
        setup(8'hFF, 8'h00, 8'h00, 8'h1F, 8'h01, 8'h01);
        cpu_write(3'd7, 8'h00);
        wait_idle("wrap");
        check("wrap_rcount", ra_q.size(), 4);
        check("wrap_wcount", wa_q.size(), 4);
        if (ra_q.size() == 4 && wa_q.size() == 4) begin
            check("wrap_r0", ra_q[0], 16'h00FF);
            check("wrap_r1", ra_q[1], 16'h01FF);
            check("wrap_r2", ra_q[2], 16'h0000);
            check("wrap_r3", ra_q[3], 16'h0100);
            check("wrap_w0", wa_q[0], 13'h1F00);
            check("wrap_w1", wa_q[1], 13'h0000);
            check("wrap_w2", wa_q[2], 13'h1F01);
            check("wrap_w3", wa_q[3], 13'h0001);
        end

        // Skip-zero start
        vram[16'h8080] = 8'h00;
        vram[16'h8081] = 8'h7F;
        setup(8'h80, 8'h80, 8'h30, 8'h01, 8'h01, 8'h00);
        cpu_write(3'd7, 8'h01);
        wait_idle("skip");
        check("skip_active", act_cycles, 5);
`ifdef VGA_READBACK_SKIP_ZERO_EN
        check("skip_count", wd_q.size(), 1);
        check("skip_data", wd_q.size() > 0 ? wd_q[0] : -1, 8'h7F);
        check("skip_addr", wa_q.size() > 0 ? wa_q[0] : -1, 13'h0131);
`else
        check("skip_count", wd_q.size(), 2);
        check("skip_data0", wd_q.size() > 0 ? wd_q[0] : -1, 8'h00);
        check("skip_data1", wd_q.size() > 1 ? wd_q[1] : -1, 8'h7F);
`endif

        // Abort a 4x4 copy after 3 pixels
        setup(8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h03);
        cpu_write(3'd7, 8'h00);
        wait_writes(3, "abort_pre");
        cpu_write(3'd7, 8'h80);
        check("abort_active", o_active, 1'b0);
        repeat (10) begin @(posedge i_clk); #1; end
        check("abort_writes", wd_q.size(), 3);
        cpu_write(3'd0, 8'h77);
        cpu_read(3'd0, rd);
        check("abort_vx_write", rd, 8'h77);

        // Reset a 4x4 copy after 3 pixels
        setup(8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h03);
        cpu_write(3'd7, 8'h00);
        wait_writes(3, "reset_pre");
        i_rst_b = 1'b0;
        #1;
        check("reset_active", o_active, 1'b0);
        check("reset_re_b", o_vram_re_b, 1'b1);
        check("reset_we_b", o_ram_we_b, 1'b1);
        @(posedge i_clk); #1;
        i_rst_b = 1'b1;
        repeat (10) begin @(posedge i_clk); #1; end
        check("reset_writes", wd_q.size(), 3);
        cpu_read(3'd4, rd);
        check("reset_width", rd, 8'h00);
        cpu_write(3'd0, 8'h77);
        cpu_read(3'd0, rd);
        check("reset_vx_write", rd, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
